// File: rtl/rt_output_merger.sv
// Merges NUM_CORES lane streams into one valid/ready stream via one-deep per-lane holds and a round-robin arbiter.
// Sticky per-lane overflow flags record samples dropped while a lane's hold was still occupied.
module rt_output_merger #(
  parameter int NUM_CORES = 34,
  parameter int DATA_W    = 28,
  parameter int EN_W      = 4,
  parameter int IDX_W     = 6,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES*DATA_W-1:0] in_data,
  input  logic [NUM_CORES*EN_W-1:0]   in_en,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CORES-1:0]        ovf_flags,
  input  logic                        clr_ovf,
  output logic [CNT_W-1:0]            sample_cnt
);

  logic [NUM_CORES-1:0]   pend_q, pend_d, ovf_q, ovf_d, lane_vld, grant_oh;
  logic [DATA_W-1:0]      hold_q [NUM_CORES];
  logic [DATA_W-1:0]      hold_d [NUM_CORES];
  logic [IDX_W-1:0]       ptr_q, ptr_d, idx_q, idx_d, grant_idx;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   vld_q, vld_d, slot_free, grant_vld;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*NUM_CORES-1:0] rot;
  int                     sel;

  // Rotate pending so that bit 0 is the lane at ptr; lowest set bit wins.
  always_comb begin
    slot_free = !vld_q || out_ready;
    rot       = {pend_q, pend_q} >> ptr_q;
    grant_vld = 1'b0;
    sel       = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_vld = 1'b1;
        sel       = k;
      end
    end
    sel = sel + int'(ptr_q);
    if (sel >= NUM_CORES) sel = sel - NUM_CORES;
    grant_vld = grant_vld && slot_free;
    grant_idx = IDX_W'(sel);
    grant_oh  = grant_vld ? (NUM_CORES'(1) << grant_idx) : '0;
  end

  always_comb begin
    pend_d   = pend_q;
    ovf_d    = clr_ovf ? '0 : ovf_q;
    lane_vld = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      hold_d[i]   = hold_q[i];
      lane_vld[i] = (in_en[i*EN_W +: EN_W] == EN_W'(1));
      if (lane_vld[i]) begin
        // A lane being drained this edge may refill its hold in the same cycle.
        if (!pend_q[i] || grant_oh[i]) begin
          hold_d[i] = in_data[i*DATA_W +: DATA_W];
          pend_d[i] = 1'b1;
        end else begin
          ovf_d[i] = 1'b1;
        end
      end else if (grant_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q + CNT_W'(vld_q && out_ready);
    if (slot_free) begin
      vld_d = grant_vld;
      if (grant_vld) begin
        data_d = hold_q[grant_idx];
        idx_d  = grant_idx;
        ptr_d  = (sel == NUM_CORES - 1) ? '0 : IDX_W'(sel + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
      ptr_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      for (int i = 0; i < NUM_CORES; i++) hold_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NUM_CORES; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign out_data   = data_q;
  assign out_idx    = idx_q;
  assign out_valid  = vld_q;
  assign ovf_flags  = ovf_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_rt_output_merger.sv
// Bench for rt_output_merger: directed scenarios with literal expectations plus a randomized run against a sample-level model.
module tb_rt_output_merger;
  localparam int N  = 34;
  localparam int DW = 28;
  localparam int EW = 4;
  localparam int IW = 6;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst, out_ready, clr_ovf;
  logic [N*DW-1:0] in_data;
  logic [N*EW-1:0] in_en;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            out_valid;
  logic [N-1:0]    ovf_flags;
  logic [CW-1:0]   sample_cnt;

  int tests = 0;
  int fails = 0;

  rt_output_merger #(.NUM_CORES(N), .DATA_W(DW), .EN_W(EW), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .ovf_flags(ovf_flags), .clr_ovf(clr_ovf), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] d28(input int v);
    logic [31:0] t;
    t = v;
    return {36'b0, t[27:0]};
  endfunction

  // Sample-level model: lane holds, pending marks, rotating search start.
  bit            m_ok = 1'b0;
  logic [DW-1:0] m_hold [N];
  bit            m_pend [N];
  int            m_ptr, m_idx;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_ovf;
  logic [CW-1:0] m_cnt;

  initial begin
    int  g, j;
    bit  free;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin m_hold[i] = '0; m_pend[i] = 1'b0; end
        m_ptr = 0; m_idx = 0; m_valid = 1'b0; m_data = '0; m_ovf = '0; m_cnt = '0;
        m_ok = 1'b1;
      end else begin
        free = !m_valid || out_ready;
        g = -1;
        if (free)
          for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && m_pend[j]) g = j;
          end
        if (m_valid && out_ready) m_cnt = m_cnt + 1;
        if (clr_ovf) m_ovf = '0;
        if (free) begin
          if (g >= 0) begin
            m_data = m_hold[g]; m_idx = g; m_valid = 1'b1; m_ptr = (g + 1) % N;
          end else m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (in_en[i*EW +: EW] == 4'd1) begin
            if (!m_pend[i] || i == g) begin
              m_hold[i] = in_data[i*DW +: DW];
              m_pend[i] = 1'b1;
            end else m_ovf[i] = 1'b1;
          end else if (i == g) m_pend[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("mdl_valid", 64'(out_valid), 64'(m_valid));
        chk("mdl_data", 64'(out_data), 64'(m_data));
        chk("mdl_idx", 64'(out_idx), 64'(m_idx));
        chk("mdl_ovf", 64'(ovf_flags), 64'(m_ovf));
        chk("mdl_cnt", 64'(sample_cnt), 64'(m_cnt));
      end
    end
  end

  task automatic clr_in();
    in_en   = '0;
    in_data = '0;
  endtask

  task automatic set_lane(input int i, input int v);
    logic [31:0] t;
    t = v;
    in_en[i*EW +: EW]   = 4'd1;
    in_data[i*DW +: DW] = t[27:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_in();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_out(input string nm, input int idx, input int v);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_idx"}, 64'(out_idx), 64'(idx));
    chk({nm, "_data"}, 64'(out_data), d28(v));
  endtask

  task automatic three_lane(input string nm, input int a, input int b, input int c);
    int val [3];
    int lane [3];
    lane = '{a, b, c};
    for (int k = 0; k < 3; k++) val[k] = (lane[k] == 0) ? 7 : (lane[k] == 3) ? -7 : 134217727;
    set_lane(0, 7); set_lane(3, -7); set_lane(33, 134217727);
    @(negedge clk); clr_in();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_out(nm, lane[k], val[k]);
    end
    @(negedge clk);
    chk({nm, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0; clr_in();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_cnt", 64'(sample_cnt), 64'd0);
    chk("idle_ovf", 64'(ovf_flags), 64'd0);

    set_lane(5, -1000);
    @(negedge clk); clr_in();
    @(negedge clk); expect_out("single", 5, -1000);
    @(negedge clk);
    chk("single_cnt", 64'(sample_cnt), 64'd1);
    chk("single_done", 64'(out_valid), 64'd0);

    do_reset();
    three_lane("rr_p0", 0, 3, 33);
    set_lane(3, 1);
    @(negedge clk); clr_in();
    repeat (2) @(negedge clk);
    three_lane("rr_p4", 33, 0, 3);

    do_reset();
    out_ready = 1'b0;
    set_lane(2, 10);
    @(negedge clk); clr_in();
    @(negedge clk); set_lane(2, 20);
    @(negedge clk); clr_in();
    @(negedge clk); set_lane(2, 30);
    @(negedge clk); clr_in();
    expect_out("stall", 2, 10);
    chk("stall_ovf2", 64'(ovf_flags[2]), 64'd1);
    out_ready = 1'b1;
    @(negedge clk); expect_out("stall_next", 2, 20);
    @(negedge clk);
    chk("stall_no30", 64'(out_valid), 64'd0);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_clr", 64'(ovf_flags), 64'd0);

    do_reset();
    for (int k = 0; k < 10; k++) begin
      clr_in();
      if (k < 8) set_lane(1, 100 * (k + 1) - 350);
      if (k >= 2) expect_out("burst", 1, 100 * (k - 1) - 350);
      @(negedge clk);
    end
    chk("burst_cnt", 64'(sample_cnt), 64'd8);
    chk("burst_ovf", 64'(ovf_flags), 64'd0);

    do_reset();
    out_ready = 1'b0;
    set_lane(4, 44); set_lane(5, 55); set_lane(6, 66);
    @(negedge clk); clr_in();
    @(negedge clk);
    expect_out("pre_rst", 4, 44);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_nostale", 64'(out_valid), 64'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      clr_in();
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 59);
        if (r < 4) set_lane(i, int'($urandom));
        else if (r == 4) begin
          in_en[i*EW +: EW]   = 4'($urandom_range(2, 15));
          in_data[i*DW +: DW] = 28'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    clr_in(); rst = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
    repeat (N + 4) @(negedge clk);
    chk("final_drain", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
